// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 hex keypad column scanner with per-key debounce and one-cycle key events.
// Define KEYPAD_ENTRY_EN to shift accepted digits into a 16-bit entry_value.
module keypad_scanner #(
    parameter int SCAN_DIV       = 50_000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_held,
    output logic [15:0] entry_value
);
    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;
    localparam logic [31:0] DIV_LAST = 32'(SCAN_DIV - 1);
    localparam logic [31:0] DEB      = 32'(DEBOUNCE_SCANS);
    state_t      state;
    logic [31:0] div, cnt;
    logic [3:0]  row_meta, rows_s, cand, acc_code;
    logic [1:0]  col_idx, low_idx;
    logic        tick, any_low, same_row, cand_low, accept;
    assign tick     = div == DIV_LAST;
    assign any_low  = rows_s != 4'hF;
    assign low_idx  = !rows_s[0] ? 2'd0 : !rows_s[1] ? 2'd1 : !rows_s[2] ? 2'd2 : 2'd3;
    assign same_row = any_low && low_idx == cand[3:2];
    assign cand_low = !rows_s[cand[3:2]];
    assign col_out  = ~(4'b0001 << col_idx);
    assign key_held = state == PRESSED || state == RELEASE;
    // A single-scan debounce accepts straight from the IDLE detection tick.
    assign accept   = tick && ((state == IDLE && any_low && DEB == 32'd1) ||
                               (state == DEBOUNCE && same_row && cnt + 32'd1 >= DEB));
    assign acc_code = state == IDLE ? {low_idx, col_idx} : cand;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) div <= '0;
        else       div <= tick ? '0 : div + 32'd1;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_meta <= 4'hF;
            rows_s   <= 4'hF;
        end else begin
            row_meta <= row_in;
            rows_s   <= row_meta;
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cand      <= '0;
            col_idx   <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
        end else begin
            key_valid <= accept;
            if (accept) key_code <= acc_code;
            if (tick) begin
                case (state)
                    IDLE: if (any_low) begin
                        cand  <= {low_idx, col_idx};
                        cnt   <= 32'd1;
                        state <= DEB == 32'd1 ? PRESSED : DEBOUNCE;
                    end else col_idx <= col_idx + 2'd1;
                    DEBOUNCE: if (!same_row) state <= IDLE;
                    else begin
                        cnt <= cnt + 32'd1;
                        if (cnt + 32'd1 >= DEB) state <= PRESSED;
                    end
                    PRESSED: if (!cand_low) begin
                        cnt   <= 32'd1;
                        state <= DEB == 32'd1 ? IDLE : RELEASE;
                    end
                    RELEASE: if (cand_low) state <= PRESSED;
                    else begin
                        cnt <= cnt + 32'd1;
                        if (cnt + 32'd1 >= DEB) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
`ifdef KEYPAD_ENTRY_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)       entry_value <= '0;
        else if (accept) entry_value <= {entry_value[11:0], acc_code};
    end
`else
    assign entry_value = 16'h0000;
`endif
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized keypad presses against a key-event scoreboard.
module tb_keypad_scanner;
    logic        clock = 1'b0, reset = 1'b1;
    logic [3:0]  row_in, col_out, key_code;
    logic        key_valid, key_held;
    logic [15:0] entry_value;
    logic [15:0] keys = '0;
    logic [15:0] entry_model = '0;
    int          checks = 0, errors = 0;
    typedef struct packed {logic [3:0] code; logic [15:0] entry;} exp_t;
    exp_t exp_q[$];
    exp_t e;
`ifdef KEYPAD_ENTRY_EN
    localparam logic [15:0] ENTRY4 = 16'h1234, ENTRY5 = 16'h2345;
`else
    localparam logic [15:0] ENTRY4 = 16'h0000, ENTRY5 = 16'h0000;
`endif

    always #5 clock = ~clock;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clock(clock), .reset(reset), .row_in(row_in), .col_out(col_out),
        .key_valid(key_valid), .key_code(key_code), .key_held(key_held),
        .entry_value(entry_value)
    );

    // Physical keypad: a closed switch at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic expect_key(input logic [3:0] code);
`ifdef KEYPAD_ENTRY_EN
        entry_model = {entry_model[11:0], code};
`endif
        exp_q.push_back(exp_t'{code: code, entry: entry_model});
    endtask

    // Press a set of keys long enough to be accepted, then release fully.
    task automatic tap(input logic [15:0] mask, input logic [3:0] code);
        expect_key(code);
        keys = mask;
        cycles(48);
        keys = '0;
        cycles(40);
    endtask

    task automatic wait_col_start(input int c);
        int n = 0;
        while (col_out[c] == 1'b0 && n < 64) begin @(negedge clock); n++; end
        while (col_out[c] == 1'b1 && n < 64) begin @(negedge clock); n++; end
        check("wait_col_timeout", 32'(n < 64), 1);
    endtask

    always @(negedge clock) begin
        if (!reset) check("col_onehot", $countones(~col_out), 1);
        if (!reset && key_valid) begin
            if (exp_q.size() == 0) check("unexpected_key_valid", {28'd0, key_code}, 32'hFFFF_FFFF);
            else begin
                e = exp_q.pop_front();
                check("key_code", key_code, e.code);
                check("entry_value", entry_value, e.entry);
                check("held_at_valid", key_held, 1);
            end
        end
    end

    initial begin
        logic [3:0] c0;
        cycles(3);
        check("rst_col", col_out, 4'b1110);
        check("rst_valid", key_valid, 0);
        check("rst_code", key_code, 0);
        check("rst_held", key_held, 0);
        check("rst_entry", entry_value, 0);
        reset = 1'b0;
        cycles(3);
        check("scan0", col_out, 4'b1110);
        cycles(1);
        check("scan1", col_out, 4'b1101);
        cycles(4);
        check("scan2", col_out, 4'b1011);
        cycles(4);
        check("scan3", col_out, 4'b0111);
        cycles(4);
        check("scan4", col_out, 4'b1110);

        expect_key(4'h9);
        keys = 16'h1 << (2*4+1);
        cycles(48);
        check("press_held", key_held, 1);
        check("press_frozen", col_out, 4'b1101);
        keys = '0;
        cycles(40);
        check("release_held", key_held, 0);
        c0 = col_out;
        cycles(4);
        check("scan_resumed", 32'(c0 != col_out), 1);

        wait_col_start(1);
        keys = 16'h1 << 1;
        cycles(5);
        keys = '0;
        cycles(8);
        check("bounce_no_hold", key_held, 0);
        tap(16'h1 << 1, 4'h1);

        expect_key(4'h6);
        keys = 16'h1 << (1*4+2);
        cycles(48);
        keys = '0;
        cycles(8);
        keys = 16'h1 << (1*4+2);
        cycles(2);
        check("glitch_held_a", key_held, 1);
        cycles(20);
        check("glitch_held_b", key_held, 1);
        keys = '0;
        cycles(40);
        check("glitch_release", key_held, 0);

        tap((16'h1 << 4) | (16'h1 << 12), 4'h4);

        expect_key(4'h9);
        keys = 16'h1 << 9;
        cycles(48);
        keys = keys | 16'h1 << 1;
        cycles(24);
        keys = 16'h1 << 9;
        cycles(24);
        check("second_ignored_code", key_code, 4'h9);
        keys = '0;
        cycles(40);

        tap(16'h1 << 1, 4'h1);
        tap(16'h1 << 2, 4'h2);
        tap(16'h1 << 3, 4'h3);
        tap(16'h1 << 4, 4'h4);
        check("entry_1234", entry_value, ENTRY4);
        tap(16'h1 << 5, 4'h5);
        check("entry_2345", entry_value, ENTRY5);

        for (int i = 0; i < 12; i++) begin
            int r, c, r2;
            logic [15:0] m;
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            m = 16'h1 << (r*4 + c);
            if ($urandom_range(0, 1) == 1 && r < 3) begin
                r2 = $urandom_range(r + 1, 3);
                m = m | 16'h1 << (r2*4 + c);
            end
            tap(m, 4'(r*4 + c));
        end

        wait_col_start(2);
        keys = 16'h1 << (3*4+2);
        cycles(6);
        reset = 1'b1;
        cycles(1);
        check("midrst_col", col_out, 4'b1110);
        check("midrst_valid", key_valid, 0);
        check("midrst_code", key_code, 0);
        check("midrst_held", key_held, 0);
        check("midrst_entry", entry_value, 0);
        keys = '0;
        entry_model = '0;
        cycles(2);
        reset = 1'b0;
        cycles(40);
        check("midrst_after_held", key_held, 0);
        tap(16'h1 << 15, 4'hF);
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
